// File: rtl/bresenham_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bresenham_pkg                                                        |
// | Shared types and width rules for the Bresenham line rasteriser.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package bresenham_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_DRAW  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int c_default_cw = 8;

  // Two extra bits hold the sign and the headroom of err +/- delta.
  function automatic int err_width(input int cw);
    return cw + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bresenham_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bresenham_step                                                       |
// | Combinational single step of the all-octant Bresenham walker.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bresenham_step
  import bresenham_pkg::*;
#(
  parameter int CW = c_default_cw
) (
  input  logic signed [err_width(CW)-1:0] i_err,
  input  logic signed [err_width(CW)-1:0] i_dx,
  input  logic signed [err_width(CW)-1:0] i_dy,
  input  logic                            i_sx_neg,
  input  logic                            i_sy_neg,
  input  logic        [CW-1:0]            i_x,
  input  logic        [CW-1:0]            i_y,
  output logic signed [err_width(CW)-1:0] o_err,
  output logic        [CW-1:0]            o_x,
  output logic        [CW-1:0]            o_y
);

  localparam int c_ew = err_width(CW);

  logic signed [c_ew:0]   w_e2;
  logic signed [c_ew:0]   w_dx_ext;
  logic signed [c_ew:0]   w_dy_ext;
  logic                   w_step_x;
  logic                   w_step_y;
  logic        [CW-1:0]   w_x_inc;
  logic        [CW-1:0]   w_y_inc;
  logic signed [c_ew-1:0] w_add_x;
  logic signed [c_ew-1:0] w_add_y;

  // Both decisions use the pre-step error, so they are evaluated in parallel.
  assign w_e2     = {i_err, 1'b0};
  assign w_dx_ext = {i_dx[c_ew-1], i_dx};
  assign w_dy_ext = {i_dy[c_ew-1], i_dy};
  assign w_step_x = (w_e2 >= w_dy_ext);
  assign w_step_y = (w_e2 <= w_dx_ext);

  assign w_add_x  = w_step_x ? i_dy : {c_ew{1'b0}};
  assign w_add_y  = w_step_y ? i_dx : {c_ew{1'b0}};
  assign o_err    = i_err + w_add_x + w_add_y;

  assign w_x_inc  = i_sx_neg ? {CW{1'b1}} : {{(CW-1){1'b0}}, 1'b1};
  assign w_y_inc  = i_sy_neg ? {CW{1'b1}} : {{(CW-1){1'b0}}, 1'b1};
  assign o_x      = w_step_x ? (i_x + w_x_inc) : i_x;
  assign o_y      = w_step_y ? (i_y + w_y_inc) : i_y;

endmodule
`default_nettype wire

// File: rtl/bresenham_stream.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bresenham_stream                                                     |
// | Streams the pixels of a line as valid/ready beats, all octants.      |
// | Optional screen clipping: define BRESENHAM_CLIP_EN.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bresenham_stream
  import bresenham_pkg::*;
#(
  parameter int CW       = c_default_cw,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] x0,
  input  logic [CW-1:0] y0,
  input  logic [CW-1:0] x1,
  input  logic [CW-1:0] y1,
  output logic          busy,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          pix_last,
  output logic          done
);

  localparam int c_ew = err_width(CW);

  state_t                 r_state;
  logic        [CW-1:0]   r_x0;
  logic        [CW-1:0]   r_y0;
  logic        [CW-1:0]   r_x1;
  logic        [CW-1:0]   r_y1;
  logic        [CW-1:0]   r_x;
  logic        [CW-1:0]   r_y;
  logic signed [c_ew-1:0] r_dx;
  logic signed [c_ew-1:0] r_dy;
  logic signed [c_ew-1:0] r_err;
  logic                   r_sx_neg;
  logic                   r_sy_neg;
  logic                   r_walk_end;

  logic signed [c_ew-1:0] w_x0e;
  logic signed [c_ew-1:0] w_y0e;
  logic signed [c_ew-1:0] w_x1e;
  logic signed [c_ew-1:0] w_y1e;
  logic signed [c_ew-1:0] w_dx;
  logic signed [c_ew-1:0] w_dy;
  logic signed [c_ew-1:0] w_err_nxt;
  logic        [CW-1:0]   w_x_nxt;
  logic        [CW-1:0]   w_y_nxt;
  logic                   w_at_end;
  logic                   w_onscreen;
  logic                   w_slot_free;

  assign w_x0e = {2'b00, r_x0};
  assign w_y0e = {2'b00, r_y0};
  assign w_x1e = {2'b00, r_x1};
  assign w_y1e = {2'b00, r_y1};

  // dx is |x1-x0|, dy is -|y1-y0|.
  assign w_dx = (r_x1 >= r_x0) ? (w_x1e - w_x0e) : (w_x0e - w_x1e);
  assign w_dy = (r_y1 >= r_y0) ? (w_y0e - w_y1e) : (w_y1e - w_y0e);

  assign w_at_end    = (r_x == r_x1) && (r_y == r_y1);
  assign w_slot_free = !pix_valid || pix_ready;

`ifdef BRESENHAM_CLIP_EN
  localparam int            c_xw    = CW + 1;
  localparam logic [CW:0]   c_scr_w = c_xw'(SCREEN_W);
  localparam logic [CW:0]   c_scr_h = c_xw'(SCREEN_H);
  assign w_onscreen = ({1'b0, r_x} < c_scr_w) && ({1'b0, r_y} < c_scr_h);
`else
  assign w_onscreen = 1'b1;
`endif

  bresenham_step #(
    .CW (CW)
  ) u_step (
    .i_err    (r_err),
    .i_dx     (r_dx),
    .i_dy     (r_dy),
    .i_sx_neg (r_sx_neg),
    .i_sy_neg (r_sy_neg),
    .i_x      (r_x),
    .i_y      (r_y),
    .o_err    (w_err_nxt),
    .o_x      (w_x_nxt),
    .o_y      (w_y_nxt)
  );

  // The walker point (r_x, r_y) feeds a one-entry output slot; the walker
  // only advances when that slot is empty or being accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_x0       <= '0;
      r_y0       <= '0;
      r_x1       <= '0;
      r_y1       <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_dx       <= '0;
      r_dy       <= '0;
      r_err      <= '0;
      r_sx_neg   <= 1'b0;
      r_sy_neg   <= 1'b0;
      r_walk_end <= 1'b0;
      busy       <= 1'b0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_last   <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_x0    <= x0;
            r_y0    <= y0;
            r_x1    <= x1;
            r_y1    <= y1;
            busy    <= 1'b1;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_dx       <= w_dx;
          r_dy       <= w_dy;
          r_err      <= w_dx + w_dy;
          r_sx_neg   <= !(r_x0 < r_x1);
          r_sy_neg   <= !(r_y0 < r_y1);
          r_x        <= r_x0;
          r_y        <= r_y0;
          r_walk_end <= 1'b0;
          r_state    <= ST_DRAW;
        end
        ST_DRAW: begin
          if (w_slot_free) begin
            if (r_walk_end) begin
              pix_valid <= 1'b0;
              pix_last  <= 1'b0;
              done      <= 1'b1;
              r_state   <= ST_DONE;
            end else begin
              pix_valid <= w_onscreen;
              pix_x     <= r_x;
              pix_y     <= r_y;
              pix_last  <= w_at_end && w_onscreen;
              if (w_at_end) begin
                r_walk_end <= 1'b1;
              end else begin
                r_x   <= w_x_nxt;
                r_y   <= w_y_nxt;
                r_err <= w_err_nxt;
              end
            end
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bresenham_stream.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bresenham_stream                                                  |
// | Self-checking bench: directed and random lines against a model.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_bresenham_stream;

  localparam int CW    = 8;
  localparam int SCR_W = 160;
  localparam int SCR_H = 120;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] x0, y0, x1, y1;
  logic          busy, pix_valid, pix_ready, pix_last, done;
  logic [CW-1:0] pix_x, pix_y;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int x;
    int y;
    bit last;
  } pt_t;

  pt_t exp_q[$];

  always #5 clk = ~clk;

  bresenham_stream #(
    .CW       (CW),
    .SCREEN_W (SCR_W),
    .SCREEN_H (SCR_H)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x0        (x0),
    .y0        (y0),
    .x1        (x1),
    .y1        (y1),
    .busy      (busy),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_last  (pix_last),
    .done      (done)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit on_screen(input int x, input int y);
`ifdef BRESENHAM_CLIP_EN
    return (x < SCR_W) && (y < SCR_H);
`else
    return 1'b1;
`endif
  endfunction

  // Reference walk using the textbook integer error-term rules.
  task automatic build_model(input int ax0, input int ay0, input int ax1, input int ay1);
    int  dx, dy, sx, sy, err, e2, x, y;
    bit  at_end;
    pt_t p;
    exp_q.delete();
    dx  = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    dy  = (ay1 > ay0) ? ay0 - ay1 : ay1 - ay0;
    sx  = (ax0 < ax1) ? 1 : -1;
    sy  = (ay0 < ay1) ? 1 : -1;
    err = dx + dy;
    x   = ax0;
    y   = ay0;
    for (int k = 0; k <= 600; k++) begin
      at_end = (x == ax1) && (y == ay1);
      if (on_screen(x, y)) begin
        p.x = x;
        p.y = y;
        p.last = at_end;
        exp_q.push_back(p);
      end
      if (at_end) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  // mode: 0 ready always high, 1 ready toggles 1,0,..., 2 random ready.
  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                          input int mode, input int rst_after, input bit poke);
    int            acc, last_acc, n_exp;
    bit            stalled, finished, rdy, first_on;
    logic [CW-1:0] hx, hy;
    logic          hl;
    pt_t           p;
    build_model(ax0, ay0, ax1, ay1);
    n_exp    = exp_q.size();
    first_on = on_screen(ax0, ay0);
    acc = 0; last_acc = 0; stalled = 0; finished = 0;
    hx = '0; hy = '0; hl = 1'b0;
    x0 = CW'(ax0); y0 = CW'(ay0); x1 = CW'(ax1); y1 = CW'(ay1);
    start = 1'b1; pix_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    x0 = CW'($urandom); y0 = CW'($urandom); x1 = CW'($urandom); y1 = CW'($urandom);
    chk("setup_busy", busy, 1);
    chk("setup_valid", pix_valid, 0);
    @(posedge clk); #1;
    chk("edge1_valid", pix_valid, 0);
    for (int cyc = 2; cyc < 3000 && !finished; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 2) chk("latency_valid", pix_valid, first_on);
      if (stalled) begin
        chk("stall_valid", pix_valid, 1);
        chk("stall_x", pix_x, hx);
        chk("stall_y", pix_y, hy);
        chk("stall_last", pix_last, hl);
      end
      if (done) begin
        if (n_exp > 0) chk("done_cycle", cyc, last_acc + 1);
        chk("pixel_count", acc, n_exp);
        start = 1'b1;
        @(posedge clk); #1;
        chk("done_pulse_len", done, 0);
        chk("idle_busy", busy, 0);
        start = 1'b0;
        finished = 1;
      end else if (rst_after > 0 && acc == rst_after) begin
        start = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_valid", pix_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (3) begin
          @(posedge clk); #1;
          chk("rst_quiet", done | busy | pix_valid, 0);
        end
        finished = 1;
      end else begin
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = (cyc % 2 == 0);
          default: rdy = ($urandom_range(0, 3) != 0);
        endcase
        pix_ready = rdy;
        start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
        stalled = pix_valid && !rdy;
        hx = pix_x; hy = pix_y; hl = pix_last;
        if (pix_valid && rdy) begin
          if (exp_q.size() == 0) begin
            chk("extra_pixel", 1, 0);
          end else begin
            p = exp_q.pop_front();
            chk("pix_x", pix_x, p.x);
            chk("pix_y", pix_y, p.y);
            chk("pix_last", pix_last, p.last);
          end
          acc++;
          last_acc = cyc;
        end
      end
    end
    if (!finished) chk("timeout", 0, 1);
    pix_ready = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pix_ready = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy0", busy, 0);
    chk("rst_valid0", pix_valid, 0);
    chk("rst_last0", pix_last, 0);
    chk("rst_done0", done, 0);
    chk("rst_x0", pix_x, 0);
    chk("rst_y0", pix_y, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_line(16, 16, 64, 64, 0, -1, 0);
    run_line(10, 5, 2, 8, 0, -1, 0);
    run_line(16, 16, 64, 64, 1, -1, 0);
    run_line(7, 7, 7, 7, 0, -1, 1);
    run_line(16, 16, 64, 64, 0, 5, 0);
    run_line(3, 200, 250, 10, 2, -1, 1);
    run_line(150, 0, 170, 0, 0, -1, 0);
    run_line(0, 0, 0, 255, 2, -1, 0);
    for (int i = 0; i < 20; i++) begin
      run_line($urandom_range(0, 255), $urandom_range(0, 255),
               $urandom_range(0, 255), $urandom_range(0, 255),
               $urandom_range(0, 2), -1, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
